// File: rtl/bit_packer.sv
`default_nettype none
// ============================================================================
// Module   : bit_packer
// Purpose  : Packs variable-length fields (0..15 bits) MSB-first into 32-bit
//            words. A flush pads any residual bits with zeros and emits them
//            as a final word.
// Ports    : clock   - single clock, rising edge
//            reset   - asynchronous, active-low reset
//            pushin  - field valid this cycle
//            lenin   - field length in bits (0..15)
//            datain  - field value, right-aligned in datain[lenin-1:0]
//            flush   - pad and emit the partial word
//            busy    - flush in progress; pushin/flush ignored while high
//            pushout - one-cycle pulse, dataout valid
//            dataout - packed word (first stream bit in dataout[31])
//            wordcnt - words emitted since reset (wraps)
//            fill    - residual bits currently held (0..31)
// Revision : 1.0 - initial release
// ============================================================================
module bit_packer #(
  parameter int CNTW = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pushin,
  input  logic [3:0]      lenin,
  input  logic [14:0]     datain,
  input  logic            flush,
  output logic            busy,
  output logic            pushout,
  output logic [31:0]     dataout,
  output logic [CNTW-1:0] wordcnt,
  output logic [4:0]      fill
);

  // 31 residual bits + 15 incoming bits + 1 bit of margin.
  localparam int c_ACCW = 47;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // Residual bits are kept right-aligned: the oldest bit sits at r_acc[r_fill-1].
  logic [c_ACCW-1:0]   r_acc;
  logic [c_ACCW-1:0]   w_acc_nxt;
  logic [c_ACCW-1:0]   w_combined;
  logic [c_ACCW-1:0]   w_keep;
  logic [4:0]          r_fill;
  logic [4:0]          w_fill_nxt;
  logic [14:0]         w_field;
  logic [5:0]          w_total;
  logic [5:0]          w_shift;
  logic                w_emit;
  logic [31:0]         w_word;
  logic                r_pushout;
  logic [31:0]         r_dataout;
  logic [CNTW-1:0]     r_wordcnt;

  // --------------------------------------------------------------------------
  // Datapath helpers: append the masked field below the residual bits.
  // --------------------------------------------------------------------------
  always_comb begin
    w_field    = datain & 15'((16'd1 << lenin) - 16'd1);
    w_combined = (r_acc << lenin) | {{(c_ACCW-15){1'b0}}, w_field};
    w_total    = {1'b0, r_fill} + {2'b00, lenin};
    // When a word completes, the bits beyond the top 32 form the new residue.
    w_shift    = w_total - 6'd32;
    // For totals 32..46 the new residue length is simply the low 5 bits.
    w_keep     = (c_ACCW'(1) << w_total[4:0]) - c_ACCW'(1);
  end

  // --------------------------------------------------------------------------
  // Next-state / next-datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_fill_nxt  = r_fill;
    w_emit      = 1'b0;
    w_word      = r_dataout;

    case (r_state)
      ST_RUN: begin
        if (pushin && (lenin != 4'd0)) begin
          if (w_total >= 6'd32) begin
            w_emit     = 1'b1;
            w_word     = 32'(w_combined >> w_shift);
            w_fill_nxt = w_total[4:0];
            w_acc_nxt  = w_combined & w_keep;
          end else begin
            w_acc_nxt  = w_combined;
            w_fill_nxt = w_total[4:0];
          end
        end
        if (flush) begin
          w_state_nxt = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        if (r_fill != 5'd0) begin
          w_emit = 1'b1;
          // Move the residue to the top of the word, zeros below it.
          w_word = r_acc[31:0] << (6'd32 - {1'b0, r_fill});
        end
        w_acc_nxt   = '0;
        w_fill_nxt  = 5'd0;
        w_state_nxt = ST_RUN;
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc     <= '0;
      r_fill    <= 5'd0;
      r_pushout <= 1'b0;
      r_dataout <= 32'd0;
      r_wordcnt <= '0;
    end else begin
      r_acc     <= w_acc_nxt;
      r_fill    <= w_fill_nxt;
      r_pushout <= w_emit;
      if (w_emit) begin
        r_dataout <= w_word;
        r_wordcnt <= r_wordcnt + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign busy    = (r_state == ST_FLUSH);
  assign pushout = r_pushout;
  assign dataout = r_dataout;
  assign wordcnt = r_wordcnt;
  assign fill    = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_bit_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_packer
// Purpose  : Self-checking bench for bit_packer. A bit-queue reference model
//            tracks the stream; directed scenarios plus randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_packer;

  localparam int CW = 4;  // small counter so wrap-around is reached quickly

  logic          clock  = 1'b0;
  logic          reset  = 1'b0;
  logic          pushin = 1'b0;
  logic [3:0]    lenin  = 4'd0;
  logic [14:0]   datain = 15'd0;
  logic          flush  = 1'b0;
  logic          busy;
  logic          pushout;
  logic [31:0]   dataout;
  logic [CW-1:0] wordcnt;
  logic [4:0]    fill;

  int total = 0;
  int bad   = 0;

  // Reference model: stream bits in order, pending flush, last emitted word.
  bit          m_q[$];
  bit          m_busy;
  bit          m_push;
  logic [31:0] m_word;
  int          m_cnt;

  bit_packer #(.CNTW(CW)) dut (
    .clock   (clock),
    .reset   (reset),
    .pushin  (pushin),
    .lenin   (lenin),
    .datain  (datain),
    .flush   (flush),
    .busy    (busy),
    .pushout (pushout),
    .dataout (dataout),
    .wordcnt (wordcnt),
    .fill    (fill)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_q.delete();
    m_busy = 1'b0;
    m_push = 1'b0;
    m_word = 32'd0;
    m_cnt  = 0;
  endtask

  // Apply one cycle of inputs, advance the model at the edge, settle 1 time unit.
  task automatic drive(input logic p, input logic [3:0] l, input logic [14:0] d, input logic f);
    logic [31:0] w;
    pushin = p; lenin = l; datain = d; flush = f;
    @(posedge clock);
    m_push = 1'b0;
    if (m_busy) begin
      if (m_q.size() > 0) begin
        w = 32'd0;
        for (int i = 0; i < 32; i++) w = {w[30:0], (m_q.size() > 0) ? m_q.pop_front() : 1'b0};
        m_push = 1'b1; m_word = w; m_cnt++;
      end
      m_busy = 1'b0;
    end else begin
      if (p) for (int i = int'(l) - 1; i >= 0; i--) m_q.push_back(d[i]);
      if (m_q.size() >= 32) begin
        w = 32'd0;
        for (int i = 0; i < 32; i++) w = {w[30:0], m_q.pop_front()};
        m_push = 1'b1; m_word = w; m_cnt++;
      end
      if (f) m_busy = 1'b1;
    end
    #1;
    pushin = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    total++; if ({busy, pushout, dataout, wordcnt, fill} !== '0) begin bad++; $display("FAIL reset_outputs got busy=%0b push=%0b data=%h cnt=%0d fill=%0d want all zero", busy, pushout, dataout, wordcnt, fill); end
    #5 reset = 1'b1;
  endtask

  task automatic test_bytes();
    for (int i = 0; i < 3; i++) drive(1'b1, 4'd8, 15'h0AB, 1'b0);
    total++; if (pushout !== 1'b0) begin bad++; $display("FAIL bytes_early_push got=%0b want=0", pushout); end
    drive(1'b1, 4'd8, 15'h0AB, 1'b0);
    total++; if (pushout !== 1'b1) begin bad++; $display("FAIL bytes_push got=%0b want=1", pushout); end
    total++; if (dataout !== 32'hABABABAB) begin bad++; $display("FAIL bytes_data got=%h want=ababab ab", dataout); end
    total++; if (wordcnt !== CW'(1)) begin bad++; $display("FAIL bytes_wordcnt got=%0d want=1", wordcnt); end
    total++; if (fill !== 5'd0) begin bad++; $display("FAIL bytes_fill got=%0d want=0", fill); end
    drive(1'b0, 4'd0, 15'd0, 1'b0);
    total++; if ({pushout, dataout} !== {1'b0, 32'hABABABAB}) begin bad++; $display("FAIL bytes_hold got push=%0b data=%h want push=0 data=abababab", pushout, dataout); end
  endtask

  task automatic test_full_flush();
    int base;
    base = m_cnt;
    for (int i = 0; i < 3; i++) drive(1'b1, 4'd15, 15'h7FFF, 1'b0);
    total++; if ({pushout, dataout} !== {1'b1, 32'hFFFFFFFF}) begin bad++; $display("FAIL full_word got push=%0b data=%h want push=1 data=ffffffff", pushout, dataout); end
    total++; if (fill !== 5'd13) begin bad++; $display("FAIL full_fill got=%0d want=13", fill); end
    drive(1'b0, 4'd0, 15'd0, 1'b1);
    total++; if ({busy, pushout} !== 2'b10) begin bad++; $display("FAIL full_busy got busy=%0b push=%0b want busy=1 push=0", busy, pushout); end
    drive(1'b0, 4'd0, 15'd0, 1'b0);
    total++; if ({busy, pushout, dataout} !== {2'b01, 32'hFFF80000}) begin bad++; $display("FAIL full_flush_word got busy=%0b push=%0b data=%h want busy=0 push=1 data=fff80000", busy, pushout, dataout); end
    total++; if (fill !== 5'd0) begin bad++; $display("FAIL full_flush_fill got=%0d want=0", fill); end
    total++; if (wordcnt !== CW'(base + 2)) begin bad++; $display("FAIL full_wordcnt got=%0d want=%0d", wordcnt, CW'(base + 2)); end
  endtask

  task automatic test_mask();
    drive(1'b1, 4'd4, 15'h7FF5, 1'b0);
    total++; if (fill !== 5'd4) begin bad++; $display("FAIL mask_fill got=%0d want=4", fill); end
    drive(1'b0, 4'd0, 15'd0, 1'b1);
    drive(1'b0, 4'd0, 15'd0, 1'b0);
    total++; if ({pushout, dataout} !== {1'b1, 32'h50000000}) begin bad++; $display("FAIL mask_word got push=%0b data=%h want push=1 data=50000000", pushout, dataout); end
  endtask

  task automatic test_empty_flush();
    logic [CW-1:0] cnt0;
    cnt0 = wordcnt;
    drive(1'b0, 4'd0, 15'd0, 1'b1);
    total++; if ({busy, pushout} !== 2'b10) begin bad++; $display("FAIL empty_busy got busy=%0b push=%0b want busy=1 push=0", busy, pushout); end
    drive(1'b1, 4'd8, 15'h0FF, 1'b1);  // ignored while busy
    total++; if ({busy, pushout, fill} !== {2'b00, 5'd0}) begin bad++; $display("FAIL empty_after got busy=%0b push=%0b fill=%0d want 0 0 0", busy, pushout, fill); end
    total++; if (wordcnt !== cnt0) begin bad++; $display("FAIL empty_wordcnt got=%0d want=%0d", wordcnt, cnt0); end
    drive(1'b0, 4'd0, 15'd0, 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL empty_busy_relapse got=%0b want=0", busy); end
  endtask

  task automatic test_push_flush();
    for (int i = 0; i < 2; i++) drive(1'b1, 4'd15, 15'h7FFF, 1'b0);
    total++; if (fill !== 5'd30) begin bad++; $display("FAIL pf_fill got=%0d want=30", fill); end
    drive(1'b1, 4'd3, 15'h0005, 1'b1);
    total++; if ({pushout, dataout, busy, fill} !== {1'b1, 32'hFFFFFFFE, 1'b1, 5'd1}) begin bad++; $display("FAIL pf_first got push=%0b data=%h busy=%0b fill=%0d want 1 fffffffe 1 1", pushout, dataout, busy, fill); end
    drive(1'b0, 4'd0, 15'd0, 1'b0);
    total++; if ({pushout, dataout, busy, fill} !== {1'b1, 32'h80000000, 1'b0, 5'd0}) begin bad++; $display("FAIL pf_second got push=%0b data=%h busy=%0b fill=%0d want 1 80000000 0 0", pushout, dataout, busy, fill); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) drive(1'b1, 4'd10, 15'h3FF, 1'b0);
    total++; if (fill !== 5'd20) begin bad++; $display("FAIL ar_fill got=%0d want=20", fill); end
    #2 reset = 1'b0;
    #1;
    total++; if ({busy, pushout, dataout, wordcnt, fill} !== '0) begin bad++; $display("FAIL ar_immediate got busy=%0b push=%0b data=%h cnt=%0d fill=%0d want all zero", busy, pushout, dataout, wordcnt, fill); end
    model_reset();
    @(posedge clock); #1;
    total++; if ({pushout, fill} !== 6'd0) begin bad++; $display("FAIL ar_held got push=%0b fill=%0d want 0 0", pushout, fill); end
    #3 reset = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 4'd8, 15'h05A, 1'b0);
    total++; if ({pushout, dataout, wordcnt, fill} !== {1'b1, 32'h5A5A5A5A, CW'(1), 5'd0}) begin bad++; $display("FAIL ar_clean got push=%0b data=%h cnt=%0d fill=%0d want 1 5a5a5a5a 1 0", pushout, dataout, wordcnt, fill); end
  endtask

  task automatic test_random();
    logic       p, f;
    logic [3:0] l;
    logic [14:0] d;
    for (int n = 0; n < 400; n++) begin
      p = ($urandom_range(3, 0) != 0);
      l = 4'($urandom_range(15, 0));
      d = 15'($urandom);
      f = ($urandom_range(9, 0) == 0);
      drive(p, l, d, f);
      total++; if (pushout !== m_push) begin bad++; $display("FAIL rnd_push cyc=%0d got=%0b want=%0b", n, pushout, m_push); end
      total++; if (dataout !== m_word) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", n, dataout, m_word); end
      total++; if (fill !== 5'(m_q.size())) begin bad++; $display("FAIL rnd_fill cyc=%0d got=%0d want=%0d", n, fill, m_q.size()); end
      total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%0b want=%0b", n, busy, m_busy); end
      total++; if (wordcnt !== CW'(m_cnt)) begin bad++; $display("FAIL rnd_wordcnt cyc=%0d got=%0d want=%0d", n, wordcnt, CW'(m_cnt)); end
    end
  endtask

  initial begin
    test_reset();
    test_bytes();
    test_full_flush();
    test_mask();
    test_empty_flush();
    test_push_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
